acc_wb_responder: RTL and testbench

ACC_WB_RESPONDER -- requirements
Module: acc_wb_responder

---
 rtl/acc_wb_responder_pkg.sv | 47 ++++
 rtl/acc_fifo.sv | 61 ++++++
 rtl/acc_wb_responder.sv | 191 +++++++++++++++++++
 tb/tb_acc_wb_responder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_wb_responder_pkg.sv
// Shared definitions for the accelerator Wishbone responder.
// Holds the register word offsets (adr[4:2]), CTRL/STATUS bit indices,
// the bus FSM state enum, the captured-request struct and the default
// FIFO depth.
package acc_wb_responder_pkg;

    localparam int FIFO_DEPTH_DEF = 4;

    // Register word offsets
    localparam logic [2:0] ADR_CTRL     = 3'd0;
    localparam logic [2:0] ADR_STATUS   = 3'd1;
    localparam logic [2:0] ADR_CFG      = 3'd2;
    localparam logic [2:0] ADR_DATA_IN  = 3'd3;
    localparam logic [2:0] ADR_DATA_OUT = 3'd4;

    // CTRL bits
    localparam int CTRL_START    = 0;
    localparam int CTRL_CLR_DONE = 1;
    localparam int CTRL_FLUSH    = 2;
    localparam int CTRL_IRQ_EN   = 3;

    // STATUS bits
    localparam int STAT_BUSY        = 0;
    localparam int STAT_DONE        = 1;
    localparam int STAT_IN_FULL     = 2;
    localparam int STAT_IN_EMPTY    = 3;
    localparam int STAT_OUT_FULL    = 4;
    localparam int STAT_OUT_EMPTY   = 5;
    localparam int STAT_UNDERFLOW   = 6;
    localparam int STAT_IRQ_EN      = 7;
    localparam int STAT_IN_CNT_LSB  = 8;
    localparam int STAT_OUT_CNT_LSB = 16;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ACK        = 2'd1,
        S_WAIT_SPACE = 2'd2
    } wb_state_e;

    // Bus request as seen by the responder (held stable until ack)
    typedef struct packed {
        logic [2:0]  word;
        logic        we;
        logic [31:0] dat;
    } wb_req_t;

endpackage

// File: rtl/acc_fifo.sv
// Synchronous FIFO used for both the input and result queues.
// Ports:
//   gclk, grst_n        clock, async active-low reset
//   flush               empties the FIFO; a push/pop in the same cycle is lost
//   push, wdata         write side (ignored when full unless popping too)
//   pop, rdata          read side, rdata is the current head (show-ahead)
//   full, empty, count  occupancy
// DEPTH must be a power of two so pointers wrap naturally.
module acc_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = AW + 1
) (
    input  logic             gclk,
    input  logic             grst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push, do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge gclk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/acc_wb_responder.sv
// Wishbone register front-end for an accelerator core.
// Ports:
//   i_clk, i_rst_n                    clock, async active-low reset
//   i_wb_*/o_wb_*                     Wishbone slave (adr[4:2] selects register)
//   o_start, o_cfg, i_busy, i_done    core control/status
//   o_in_*/i_in_ready                 input FIFO towards the core
//   i_out_*/o_out_ready               result FIFO from the core
//   o_irq                             level interrupt, DONE & IRQ_EN
// One request is served at a time: IDLE -> ACK (latency 1), or
// IDLE -> WAIT_SPACE -> ACK when a DATA_IN push finds the input FIFO full.
// All side effects happen on the transition into ACK.
module acc_wb_responder
    import acc_wb_responder_pkg::*;
#(
    parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter logic [31:0] CFG_RESET  = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_start,
    output logic [31:0] o_cfg,
    input  logic        i_busy,
    input  logic        i_done,
    output logic [31:0] o_in_data,
    output logic        o_in_valid,
    input  logic        i_in_ready,
    input  logic [31:0] i_out_data,
    input  logic        i_out_valid,
    output logic        o_out_ready,
    output logic        o_irq
);

    localparam int CW           = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
    localparam int START_STAGES = 1;

    // Reset: asserts immediately, releases two clocks after i_rst_n rises
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    wb_req_t req;
    logic    unused_adr;
    assign req        = {i_wb_adr[4:2], i_wb_we, i_wb_dat};
    assign unused_adr = ^{i_wb_adr[31:5], i_wb_adr[1:0]};

    wb_state_e state, state_nxt;
    logic      go;

    logic [31:0]   cfg_q, rdt_q, rd_data, status;
    logic          done_q, underflow_q, irq_en_q;
    logic [START_STAGES:0] vld_pipe;

    logic          in_full, in_empty, out_full, out_empty;
    logic [CW-1:0] in_cnt, out_cnt;
    logic [31:0]   in_rdata, out_rdata;

    // Request decode
    logic is_din_wr, wr_ctrl, wr_cfg, wr_din, rd_status, rd_dout, flush;

    assign is_din_wr = req.we && (req.word == ADR_DATA_IN);
    assign wr_ctrl   = go &  req.we & (req.word == ADR_CTRL);
    assign wr_cfg    = go &  req.we & (req.word == ADR_CFG);
    assign wr_din    = go &  is_din_wr;
    assign rd_status = go & ~req.we & (req.word == ADR_STATUS);
    assign rd_dout   = go & ~req.we & (req.word == ADR_DATA_OUT);
    assign flush     = wr_ctrl & req.dat[CTRL_FLUSH];

    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_wb_cyc) begin
                    if (is_din_wr && in_full) begin
                        state_nxt = S_WAIT_SPACE;
                    end else begin
                        state_nxt = S_ACK;
                        go        = 1'b1;
                    end
                end
            end
            S_WAIT_SPACE: begin
                if (!in_full) begin
                    state_nxt = S_ACK;
                    go        = 1'b1;
                end
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        status                                 = '0;
        status[STAT_BUSY]                      = i_busy;
        status[STAT_DONE]                      = done_q;
        status[STAT_IN_FULL]                   = in_full;
        status[STAT_IN_EMPTY]                  = in_empty;
        status[STAT_OUT_FULL]                  = out_full;
        status[STAT_OUT_EMPTY]                 = out_empty;
        status[STAT_UNDERFLOW]                 = underflow_q;
        status[STAT_IRQ_EN]                    = irq_en_q;
        status[STAT_IN_CNT_LSB +: 8]           = 8'(in_cnt);
        status[STAT_OUT_CNT_LSB +: 8]          = 8'(out_cnt);
    end

    // Write-only and unmapped words read as zero
    always_comb begin
        rd_data = '0;
        if (!req.we) begin
            case (req.word)
                ADR_STATUS:   rd_data = status;
                ADR_CFG:      rd_data = cfg_q;
                ADR_DATA_OUT: rd_data = out_empty ? 32'h0 : out_rdata;
                default:      rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rdt_q       <= '0;
            cfg_q       <= CFG_RESET;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
            irq_en_q    <= 1'b0;
            vld_pipe    <= '0;
        end else begin
            state <= state_nxt;
            // Loaded only on entry to ACK, so rdt is zero outside the ack cycle
            rdt_q <= go ? rd_data : 32'h0;
            if (wr_cfg)  cfg_q    <= req.dat;
            if (wr_ctrl) irq_en_q <= req.dat[CTRL_IRQ_EN];
            // Set wins over a coincident clear
            done_q <= i_done | (done_q & ~(wr_ctrl & req.dat[CTRL_CLR_DONE]));
            if (rd_dout && out_empty) underflow_q <= 1'b1;
            else if (rd_status)       underflow_q <= 1'b0;
            // Start accepted in the go cycle, seen by the core after the ack cycle
            vld_pipe <= {vld_pipe[START_STAGES-1:0], wr_ctrl & req.dat[CTRL_START] & ~i_busy};
        end
    end

    acc_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .gclk   (i_clk),
        .grst_n (rst_n),
        .flush  (flush),
        .push   (wr_din),
        .wdata  (req.dat),
        .pop    (i_in_ready),
        .rdata  (in_rdata),
        .full   (in_full),
        .empty  (in_empty),
        .count  (in_cnt)
    );

    // Core push is gated by o_out_ready so a word is only taken on a handshake
    acc_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .gclk   (i_clk),
        .grst_n (rst_n),
        .flush  (flush),
        .push   (i_out_valid & ~out_full),
        .wdata  (i_out_data),
        .pop    (rd_dout),
        .rdata  (out_rdata),
        .full   (out_full),
        .empty  (out_empty),
        .count  (out_cnt)
    );

    assign o_wb_rdt    = rdt_q;
    assign o_wb_ack    = (state == S_ACK);
    assign o_start     = vld_pipe[START_STAGES];
    assign o_cfg       = cfg_q;
    assign o_in_data   = in_rdata;
    assign o_in_valid  = ~in_empty;
    assign o_out_ready = ~out_full;
    assign o_irq       = done_q & irq_en_q;

endmodule

// File: tb/tb_acc_wb_responder.sv
// Directed + randomized bench for acc_wb_responder with a queue-based
// reference model of the register map and both FIFOs.
module tb_acc_wb_responder;

    localparam int          D       = 4;
    localparam logic [31:0] CFG_RST = 32'h1234_5678;

    logic        i_clk, i_rst_n;
    logic [31:0] i_wb_adr, i_wb_dat, o_wb_rdt;
    logic        i_wb_we, i_wb_cyc, o_wb_ack, o_start;
    logic [31:0] o_cfg, o_in_data, i_out_data;
    logic        i_busy, i_done, o_in_valid, i_in_ready, i_out_valid, o_out_ready, o_irq;

    acc_wb_responder #(.FIFO_DEPTH(D), .CFG_RESET(CFG_RST)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc),
        .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
        .o_start(o_start), .o_cfg(o_cfg), .i_busy(i_busy), .i_done(i_done),
        .o_in_data(o_in_data), .o_in_valid(o_in_valid), .i_in_ready(i_in_ready),
        .i_out_data(i_out_data), .i_out_valid(i_out_valid), .o_out_ready(o_out_ready),
        .o_irq(o_irq)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model
    logic [31:0] in_q[$];
    logic [31:0] out_q[$];
    logic [31:0] m_cfg;
    logic        m_done, m_uf, m_irq_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        in_q.delete();
        out_q.delete();
        m_cfg    = CFG_RST;
        m_done   = 1'b0;
        m_uf     = 1'b0;
        m_irq_en = 1'b0;
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s        = '0;
        s[0]     = i_busy;
        s[1]     = m_done;
        s[2]     = (in_q.size() == D);
        s[3]     = (in_q.size() == 0);
        s[4]     = (out_q.size() == D);
        s[5]     = (out_q.size() == 0);
        s[6]     = m_uf;
        s[7]     = m_irq_en;
        s[15:8]  = 8'(in_q.size());
        s[23:16] = 8'(out_q.size());
        return s;
    endfunction

    task automatic chk_outs(input string tag);
        chk({tag, " cfg"}, o_cfg, m_cfg);
        chk({tag, " in_valid"}, 32'(o_in_valid), 32'(in_q.size() != 0));
        chk({tag, " out_ready"}, 32'(o_out_ready), 32'(out_q.size() < D));
        chk({tag, " irq"}, 32'(o_irq), 32'(m_done & m_irq_en));
        if (in_q.size() != 0) chk({tag, " in_head"}, o_in_data, in_q[0]);
    endtask

    // One bus transaction expected to ack with latency 1. Optional core push /
    // done pulse driven during the request cycle only.
    task automatic bus(input logic we, input logic [2:0] word, input logic [31:0] dat,
                       input logic cpush, input logic [31:0] cdat, input logic cdone,
                       output logic [31:0] rdt);
        logic [31:0] a;
        int lat;
        a        = $urandom();
        a[4:2]   = word;
        i_wb_adr = a;
        i_wb_dat = dat;
        i_wb_we  = we;
        i_wb_cyc = 1'b1;
        i_out_valid = cpush;
        i_out_data  = cdat;
        i_done      = cdone;
        lat = 0;
        do begin
            @(posedge i_clk); #1;
            lat++;
            i_out_valid = 1'b0;
            i_done      = 1'b0;
        end while (!o_wb_ack && lat < 20);
        rdt      = o_wb_rdt;
        i_wb_cyc = 1'b0;
        i_wb_we  = 1'b0;
        chk($sformatf("ack_latency w%0d a%0d", we, word), 32'(lat), 32'd1);
        @(posedge i_clk); #1;
        chk("ack_single_cycle", 32'(o_wb_ack), 32'd0);
        chk("rdt_zero_idle", o_wb_rdt, 32'd0);
    endtask

    task automatic op(input logic we, input logic [2:0] word, input logic [31:0] dat,
                      input logic cpush, input logic [31:0] cdat, input logic cdone);
        logic [31:0] exp, rdt;
        int osz;
        logic clr, fl, exp_start;
        exp = '0;
        if (!we) begin
            if (word == 3'd1)      exp = m_status();
            else if (word == 3'd2) exp = m_cfg;
            else if (word == 3'd4 && out_q.size() > 0) exp = out_q[0];
        end
        osz       = out_q.size();
        exp_start = we && word == 3'd0 && dat[0] && !i_busy;
        bus(we, word, dat, cpush, cdat, cdone, rdt);
        chk($sformatf("rdt w%0d a%0d", we, word), rdt, exp);
        fl  = we && word == 3'd0 && dat[2];
        clr = we && word == 3'd0 && dat[1];
        if (we) begin
            if (word == 3'd0) m_irq_en = dat[3];
            if (word == 3'd2) m_cfg = dat;
            if (word == 3'd3) in_q.push_back(dat);
        end else begin
            if (word == 3'd1) m_uf = 1'b0;
            if (word == 3'd4) begin
                if (osz == 0) m_uf = 1'b1;
                else void'(out_q.pop_front());
            end
        end
        if (cpush && osz < D) out_q.push_back(cdat);
        if (fl) begin
            in_q.delete();
            out_q.delete();
        end
        m_done = cdone | (m_done & !clr);
        if (we && word == 3'd0) begin
            chk("start_pulse", 32'(o_start), 32'(exp_start));
            @(posedge i_clk); #1;
            chk("start_single", 32'(o_start), 32'd0);
        end
        chk_outs($sformatf("op w%0d a%0d", we, word));
    endtask

    task automatic wr(input logic [2:0] word, input logic [31:0] dat);
        op(1'b1, word, dat, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic rd(input logic [2:0] word);
        op(1'b0, word, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic core_pop();
        chk("core_pop valid", 32'(o_in_valid), 32'(in_q.size() != 0));
        if (in_q.size() != 0) chk("core_pop head", o_in_data, in_q[0]);
        i_in_ready = 1'b1;
        @(posedge i_clk); #1;
        i_in_ready = 1'b0;
        if (in_q.size() != 0) void'(in_q.pop_front());
    endtask

    task automatic core_push(input logic [31:0] w);
        i_out_valid = 1'b1;
        i_out_data  = w;
        @(posedge i_clk); #1;
        i_out_valid = 1'b0;
        if (out_q.size() < D) out_q.push_back(w);
        chk_outs("core_push");
    endtask

    task automatic pulse_done();
        i_done = 1'b1;
        @(posedge i_clk); #1;
        i_done = 1'b0;
        m_done = 1'b1;
        chk_outs("done");
    endtask

    initial begin
        logic [31:0] w[4];
        logic [2:0]  bad_wr[5];
        logic [2:0]  bad_rd[5];
        bad_wr = '{3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        bad_rd = '{3'd0, 3'd3, 3'd5, 3'd6, 3'd7};

        i_rst_n = 1'b0; i_wb_adr = '0; i_wb_dat = '0; i_wb_we = 1'b0; i_wb_cyc = 1'b0;
        i_busy = 1'b0; i_done = 1'b0; i_in_ready = 1'b0; i_out_data = '0; i_out_valid = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst ack", 32'(o_wb_ack), 32'd0);
        chk("rst rdt", o_wb_rdt, 32'd0);
        chk("rst start", 32'(o_start), 32'd0);
        chk_outs("rst");
        i_rst_n = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        rd(3'd1);

        // CFG write / read-back
        wr(3'd2, 32'hA5A5_0003);
        rd(3'd2);

        // Underflow, sticky until STATUS read
        rd(3'd4);
        rd(3'd1);
        rd(3'd1);

        // Start / done / irq
        wr(3'd0, 32'h8);
        wr(3'd0, 32'h9);
        pulse_done();
        op(1'b1, 3'd0, 32'hA, 1'b0, 32'h0, 1'b1);
        wr(3'd0, 32'hA);
        i_busy = 1'b1;
        wr(3'd0, 32'h9);
        rd(3'd1);
        i_busy = 1'b0;

        // Result FIFO with concurrent core push and CPU pop
        for (int k = 0; k < 4; k++) w[k] = $urandom();
        core_push(w[0]);
        for (int k = 0; k < 3; k++) op(1'b0, 3'd4, 32'h0, 1'b1, w[k+1], 1'b0);
        rd(3'd1);
        rd(3'd4);
        core_push($urandom());
        op(1'b1, 3'd0, 32'hC, 1'b1, $urandom(), 1'b0);
        rd(3'd1);

        // Randomized mix
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 9))
                0: wr(3'd2, $urandom());
                1: rd(3'd2);
                2: rd(3'd1);
                3: if (in_q.size() < D) wr(3'd3, $urandom()); else core_pop();
                4: rd(3'd4);
                5: core_push($urandom());
                6: core_pop();
                7: op(1'b1, 3'd0, $urandom() & 32'hE, 1'b0, 32'h0, 1'($urandom_range(0, 1)));
                8: if ($urandom_range(0, 1) == 1) wr(bad_wr[$urandom_range(0, 4)], $urandom());
                   else rd(bad_rd[$urandom_range(0, 4)]);
                default: pulse_done();
            endcase
        end

        // Input FIFO full: fifth push waits for space
        wr(3'd0, 32'hC);
        pulse_done();
        for (int k = 1; k <= 4; k++) wr(3'd3, 32'(k));
        rd(3'd1);
        i_wb_adr = 32'h0000_000C; i_wb_dat = 32'd5; i_wb_we = 1'b1; i_wb_cyc = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge i_clk); #1;
            chk("wait_space no ack", 32'(o_wb_ack), 32'd0);
        end
        chk("wait_space head", o_in_data, in_q[0]);
        i_in_ready = 1'b1;
        @(posedge i_clk); #1;
        i_in_ready = 1'b0;
        void'(in_q.pop_front());
        chk("wait_space pop cycle ack", 32'(o_wb_ack), 32'd0);
        @(posedge i_clk); #1;
        chk("wait_space ack", 32'(o_wb_ack), 32'd1);
        i_wb_cyc = 1'b0; i_wb_we = 1'b0;
        in_q.push_back(32'd5);
        @(posedge i_clk); #1;
        chk("wait_space ack drop", 32'(o_wb_ack), 32'd0);
        chk_outs("after wait_space");
        rd(3'd1);

        // Reset during WAIT_SPACE
        i_wb_adr = 32'h0000_000C; i_wb_dat = 32'd6; i_wb_we = 1'b1; i_wb_cyc = 1'b1;
        repeat (2) begin
            @(posedge i_clk); #1;
            chk("pre-reset no ack", 32'(o_wb_ack), 32'd0);
        end
        #2 i_rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid-rst ack", 32'(o_wb_ack), 32'd0);
        chk("mid-rst rdt", o_wb_rdt, 32'd0);
        chk("mid-rst start", 32'(o_start), 32'd0);
        chk_outs("mid-rst");
        @(posedge i_clk); #1;
        chk("rst hold ack", 32'(o_wb_ack), 32'd0);
        i_wb_cyc = 1'b0; i_wb_we = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        repeat (3) begin
            @(posedge i_clk); #1;
            chk("post-rst ack", 32'(o_wb_ack), 32'd0);
        end
        chk_outs("post-rst");
        rd(3'd1);
        rd(3'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
